// File: rtl/movement_sequencer.sv
// movement_sequencer: per-frame controller for the movement datapath.
// Each accepted frame tick runs an erase/step/redraw pass for the crosshair and,
// on bird frames, a second pass for the bird. control mirrors the registered state.
module movement_sequencer #(
  parameter int FRAME_CYCLES = 833334,
  parameter int BIRD_DIV     = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       p_left,
  input  logic       p_right,
  input  logic       p_up,
  input  logic       p_down,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_up,
  input  logic       b_down,
  input  logic       draw_done,
  input  logic       freeze,
  output logic [3:0] control,
  output logic       PorB,
  output logic       busy,
  output logic       frame_overrun,
  output logic       timeout_err
);

  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int BW = (BIRD_DIV > 1) ? $clog2(BIRD_DIV) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [BW-1:0] BIRD_LAST  = BW'(BIRD_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  // State encoding doubles as the datapath control code.
  typedef enum logic [3:0] {
    HOLD    = 4'b0000,
    PREHOLD = 4'b0100,
    CLEAR   = 4'b0001,
    LEFT    = 4'b0011,
    RIGHT   = 4'b0010,
    DOWN    = 4'b0110,
    UP      = 4'b0111,
    DRAW    = 4'b0101
  } state_t;

  state_t          state_q, state_d;
  logic            porb_q, porb_d;
  logic [FW-1:0]   frame_cnt_q;
  logic [BW-1:0]   bird_cnt_q;
  logic            bird_frame_q;
  logic [WW-1:0]   wait_q;
  logic [7:0]      req_q;
  logic            overrun_q;
  logic            timeout_q;

  logic            tick;
  logic            tick_ok;
  logic            in_wait;
  logic            wait_done;
  logic            wait_last;
  logic            step_ok;
  logic [3:0]      sel;
  logic            mv_l, mv_r, mv_d, mv_u;

  // Snapshot layout: {p_left, p_right, p_down, p_up, b_left, b_right, b_down, b_up}.
  // Opposing requests cancel, so at most one horizontal and one vertical step.
  assign sel  = porb_q ? req_q[3:0] : req_q[7:4];
  assign mv_l = sel[3] & ~sel[2];
  assign mv_r = sel[2] & ~sel[3];
  assign mv_d = sel[1] & ~sel[0];
  assign mv_u = sel[0] & ~sel[1];

  // Ticks are only accepted in HOLD; nothing is queued.
  assign tick    = (frame_cnt_q == FRAME_LAST);
  assign tick_ok = tick & ~freeze & (state_q == HOLD);

  // draw_done in the first wait cycle belongs to the previous sweep and is ignored.
  assign in_wait   = (state_q == CLEAR) | (state_q == DRAW);
  assign wait_done = draw_done & (wait_q != '0);
  assign wait_last = (wait_q == WAIT_LAST);
  assign step_ok   = in_wait & (wait_done | wait_last);

  // State register and pass select; PorB only moves with state transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      porb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      porb_q  <= porb_d;
    end
  end

  // Next-state logic: erase, ordered steps (LEFT, RIGHT, DOWN, UP), redraw.
  always_comb begin
    state_d = state_q;
    porb_d  = porb_q;
    unique case (state_q)
      HOLD: begin
        if (tick_ok) begin
          state_d = PREHOLD;
          porb_d  = 1'b0;
        end
      end
      PREHOLD: state_d = CLEAR;
      CLEAR: begin
        if (step_ok) begin
          if (mv_l)      state_d = LEFT;
          else if (mv_r) state_d = RIGHT;
          else if (mv_d) state_d = DOWN;
          else if (mv_u) state_d = UP;
          else           state_d = DRAW;
        end
      end
      LEFT, RIGHT: begin
        if (mv_d)      state_d = DOWN;
        else if (mv_u) state_d = UP;
        else           state_d = DRAW;
      end
      DOWN, UP: state_d = DRAW;
      DRAW: begin
        if (step_ok) begin
          if (!porb_q && bird_frame_q) begin
            state_d = PREHOLD;
            porb_d  = 1'b1;
          end else begin
            state_d = HOLD;
            porb_d  = 1'b0;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Frame timing, bird cadence, request snapshot, wait counter and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q  <= '0;
      bird_cnt_q   <= '0;
      bird_frame_q <= 1'b0;
      wait_q       <= '0;
      req_q        <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      frame_cnt_q <= tick ? '0 : frame_cnt_q + 1'b1;
      if (tick_ok) begin
        bird_frame_q <= (bird_cnt_q == '0);
        bird_cnt_q   <= (bird_cnt_q == BIRD_LAST) ? '0 : bird_cnt_q + 1'b1;
        req_q        <= {p_left, p_right, p_down, p_up, b_left, b_right, b_down, b_up};
      end
      if (state_d != state_q) wait_q <= '0;
      else if (in_wait)       wait_q <= wait_q + 1'b1;
      if (tick && !freeze && (state_q != HOLD)) overrun_q <= 1'b1;
      if (in_wait && wait_last && !wait_done)   timeout_q <= 1'b1;
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    control       = state_q;
    PorB          = porb_q;
    busy          = (state_q != HOLD);
    frame_overrun = overrun_q;
    timeout_err   = timeout_q;
  end

endmodule

// File: tb/tb_movement_sequencer.sv
// Bench for movement_sequencer: random move requests per frame, expected code
// stream built from the pass rules, draw_done answered by a simple datapath stand-in.
module tb_movement_sequencer;

  localparam int FC = 64;
  localparam int BD = 2;
  localparam int TO = 32;

  localparam logic [3:0] C_HOLD  = 4'b0000;
  localparam logic [3:0] C_PRE   = 4'b0100;
  localparam logic [3:0] C_CLR   = 4'b0001;
  localparam logic [3:0] C_LEFT  = 4'b0011;
  localparam logic [3:0] C_RIGHT = 4'b0010;
  localparam logic [3:0] C_DOWN  = 4'b0110;
  localparam logic [3:0] C_UP    = 4'b0111;
  localparam logic [3:0] C_DRAW  = 4'b0101;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       p_left = 1'b0, p_right = 1'b0, p_up = 1'b0, p_down = 1'b0;
  logic       b_left = 1'b0, b_right = 1'b0, b_up = 1'b0, b_down = 1'b0;
  logic       draw_done = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] control;
  logic       PorB, busy, frame_overrun, timeout_err;

  movement_sequencer #(.FRAME_CYCLES(FC), .BIRD_DIV(BD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_left(p_left), .p_right(p_right), .p_up(p_up), .p_down(p_down),
    .b_left(b_left), .b_right(b_right), .b_up(b_up), .b_down(b_down),
    .draw_done(draw_done), .freeze(freeze),
    .control(control), .PorB(PorB), .busy(busy),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; the frame counter runs in lockstep with it.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Datapath stand-in. Modes: 0 pulse 4 cycles after entry, 1 silent in CLEAR,
  // 2 also pulse on the entry cycle, 3 silent everywhere.
  int         dd_mode = 0;
  int         age = 0;
  logic [3:0] prev_ctl = 4'b0000;
  always @(posedge clk) begin
    #1;
    if ((control == C_CLR || control == C_DRAW) && control != prev_ctl) age = 0;
    else age = age + 1;
    prev_ctl = control;
    draw_done = 1'b0;
    if (control == C_CLR || control == C_DRAW) begin
      if (!(dd_mode == 3 || (dd_mode == 1 && control == C_CLR)) && age == 4) draw_done = 1'b1;
      if (dd_mode == 2 && age == 0) draw_done = 1'b1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic [3:0] code; logic porb; } step_t;
  step_t expq[$];

  int acc_frames = 0;
  int target = FC;
  bit exp_ovr = 1'b0;
  bit exp_to = 1'b0;

  task automatic push_n(input logic [3:0] c, input logic pb, input int n);
    step_t s;
    s.code = c;
    s.porb = pb;
    for (int i = 0; i < n; i++) expq.push_back(s);
  endtask

  // One pass: r = {left, right, down, up} from the frame-start snapshot.
  task automatic add_pass(input logic pb, input logic [3:0] r, input int mode);
    int clr;
    int drw;
    clr = (mode == 1 || mode == 3) ? TO : 5;
    drw = (mode == 3) ? TO : 5;
    push_n(C_PRE, pb, 1);
    push_n(C_CLR, pb, clr);
    if (r[3] != r[2]) push_n(r[3] ? C_LEFT : C_RIGHT, pb, 1);
    if (r[1] != r[0]) push_n(r[1] ? C_DOWN : C_UP, pb, 1);
    push_n(C_DRAW, pb, drw);
  endtask

  task automatic set_reqs(input logic [7:0] r);
    {p_left, p_right, p_down, p_up, b_left, b_right, b_down, b_up} = r;
  endtask

  // reqs = {p_left, p_right, p_down, p_up, b_left, b_right, b_down, b_up}
  task automatic run_frame(input logic [7:0] reqs, input int mode, input bit abort_bird);
    bit bird;
    bit aborted;
    int len;
    aborted = 1'b0;
    set_reqs(reqs);
    while (cyc < target - 1) begin
      chk("idle_ctl", 8'(control), 8'(C_HOLD));
      @(negedge clk);
    end
    chk("pretick_ctl", 8'(control), 8'(C_HOLD));
    chk("pretick_busy", 8'(busy), 8'd0);
    dd_mode = mode;
    bird = (acc_frames % BD == 0);
    acc_frames++;
    expq.delete();
    add_pass(1'b0, reqs[7:4], mode);
    if (bird) add_pass(1'b1, reqs[3:0], mode);
    len = expq.size();
    push_n(C_HOLD, 1'b0, 1);
    foreach (expq[i]) begin
      if (!aborted) begin
        @(negedge clk);
        set_reqs(8'($urandom));
        chk("ctl", 8'(control), 8'(expq[i].code));
        chk("porb", 8'(PorB), 8'(expq[i].porb));
        chk("busy", 8'(busy), 8'(expq[i].code != C_HOLD));
        if (abort_bird && expq[i].porb && expq[i].code == C_DRAW) begin
          #2 reset_n = 1'b0;
          #1;
          chk("rst_ctl", 8'(control), 8'(C_HOLD));
          chk("rst_porb", 8'(PorB), 8'd0);
          chk("rst_busy", 8'(busy), 8'd0);
          chk("rst_ovr", 8'(frame_overrun), 8'd0);
          chk("rst_to", 8'(timeout_err), 8'd0);
          @(negedge clk);
          reset_n = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    dd_mode = 0;
    if (aborted) begin
      target = FC;
      acc_frames = 0;
      exp_ovr = 1'b0;
      exp_to = 1'b0;
    end else begin
      if (len > FC - 1) exp_ovr = 1'b1;
      if (mode == 1 || mode == 3) exp_to = 1'b1;
      target = target + FC * ((len + FC) / FC);
      chk("overrun", 8'(frame_overrun), 8'(exp_ovr));
      chk("timeout", 8'(timeout_err), 8'(exp_to));
    end
  endtask

  task automatic align_bird(input bit want_bird);
    if ((acc_frames % BD == 0) != want_bird) run_frame(8'($urandom), 0, 1'b0);
  endtask

  initial begin
    #12;
    chk("reset_ctl", 8'(control), 8'(C_HOLD));
    chk("reset_porb", 8'(PorB), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_ovr", 8'(frame_overrun), 8'd0);
    chk("reset_to", 8'(timeout_err), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Crosshair right+down with a bird pass, then a crosshair-only frame.
    run_frame(8'b0110_0000, 0, 1'b0);
    run_frame(8'($urandom), 0, 1'b0);

    // Random request mixes across bird and non-bird frames.
    for (int k = 0; k < 6; k++) run_frame(8'($urandom), 0, 1'b0);

    // Conflicting horizontals plus up: only UP between CLEAR and DRAW.
    run_frame({4'b1101, 4'($urandom)}, 0, 1'b0);

    // Stale draw_done on the first wait cycle is ignored.
    run_frame(8'($urandom), 2, 1'b0);

    // Freeze: two ticks ignored, no pass, no overrun.
    freeze = 1'b1;
    while (cyc < target + 2 * FC - 8) begin
      set_reqs(8'($urandom));
      chk("frz_busy", 8'(busy), 8'd0);
      @(negedge clk);
    end
    freeze = 1'b0;
    target = target + 2 * FC;
    chk("frz_ovr", 8'(frame_overrun), 8'(exp_ovr));

    // CLEAR wait forced by timeout on a crosshair-only frame; flag stays set.
    align_bird(1'b0);
    run_frame(8'($urandom), 1, 1'b0);
    run_frame(8'($urandom), 0, 1'b0);

    // draw_done never arrives: pass overruns the next tick.
    run_frame(8'($urandom), 3, 1'b0);
    run_frame(8'($urandom), 0, 1'b0);

    // Reset during the bird DRAW, then restart from the first tick.
    align_bird(1'b1);
    run_frame(8'($urandom), 0, 1'b1);
    run_frame(8'($urandom), 0, 1'b0);
    run_frame(8'($urandom), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
